spi_master_scheduler: RTL and testbench

Shares one SPI master shift engine among `N_REQ` requesters, each owning one slave select line.
- Arbitrates pending byte transfers round-robin and generates SCLK, the active-low CS lines and MOSI.
- Samples MISO and returns the received byte to the granted requester.
- Sits between on-chip clients and the external SPI bus, which is driven by the existing `Slave` endpoints.
- Bus mode matches those slaves: SCLK idles low, LSB first, MOSI updated on SCLK rise, MISO sampled on SCLK fall.

---
 rtl/spi_defs_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/spi_master_scheduler.sv | 150 +++++++++++++++
 tb/tb_spi_master_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_defs_pkg.sv
// spi_defs: shared FSM encoding and constants for the SPI master scheduler.
package spi_defs;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_e;
    localparam int DEF_DATA_W = 8;
    localparam logic [7:0] CS_IDLE = 8'hFF;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     any
);
    localparam int PW = $clog2(N_REQ);
    logic [PW-1:0] cand;
    always_comb begin
        grant = '0;
        idx = ptr;
        any = |req;
        cand = ptr;
        // walk from farthest to nearest so the closest requester after ptr wins
        for (int k = N_REQ; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                grant = '0;
                grant[cand] = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/spi_master_scheduler.sv
// spi_master_scheduler: one SPI shift engine shared round-robin among N_REQ
// requesters; SCLK idles low, LSB first, MOSI on rise, MISO sampled on fall.
module spi_master_scheduler
    import spi_defs::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    busy,
    output logic                    SCLK,
    output logic [N_REQ-1:0]        CS,
    output logic                    MOSI,
    input  logic                    MISO
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
    logic [PW-1:0]     ptr_q, ptr_d, gnt_q, gnt_d;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, cs_q, cs_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d;
    logic [N_REQ-1:0]  arb_oh;
    logic [PW-1:0]     arb_idx;
    logic              arb_any, div_done;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_oh),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign div_done = div_q == '0;

    always_comb begin
        state_d = state_q;
        div_d = div_done ? DIV_LAST : div_q - CW'(1);
        bit_d = bit_q;
        tx_d = tx_q;
        rx_d = rx_q;
        rsp_data_d = rsp_data_q;
        ptr_d = ptr_q;
        gnt_d = gnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        cs_d = cs_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        case (state_q)
            S_IDLE: begin
                div_d = DIV_LAST;
                if (arb_any) begin
                    state_d = S_SETUP;
                    tx_d = req_data[arb_idx*DATA_W +: DATA_W];
                    req_ready_d = arb_oh;
                    cs_d = ~arb_oh;
                    ptr_d = arb_idx;
                    gnt_d = arb_idx;
                    bit_d = '0;
                    mosi_d = 1'b0;
                end
            end
            S_SETUP: if (div_done) begin
                state_d = S_HIGH;
                sclk_d = 1'b1;
                mosi_d = tx_q[0];
                tx_d = tx_q >> 1;
            end
            S_HIGH: if (div_done) begin
                state_d = S_LOW;
                sclk_d = 1'b0;
                rx_d = {MISO, rx_q[DATA_W-1:1]};
            end
            S_LOW: if (div_done) begin
                if (bit_q == BW'(DATA_W - 1)) begin
                    state_d = S_GAP;
                    cs_d = CS_IDLE[N_REQ-1:0];
                    mosi_d = 1'b0;
                    rsp_data_d = rx_q;
                    rsp_valid_d[gnt_q] = 1'b1;
                end else begin
                    state_d = S_HIGH;
                    bit_d = bit_q + BW'(1);
                    sclk_d = 1'b1;
                    mosi_d = tx_q[0];
                    tx_d = tx_q >> 1;
                end
            end
            S_GAP: if (div_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q <= DIV_LAST;
            bit_q <= '0;
            tx_q <= '0;
            rx_q <= '0;
            rsp_data_q <= '0;
            ptr_q <= PW'(N_REQ - 1);
            gnt_q <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            cs_q <= CS_IDLE[N_REQ-1:0];
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q <= div_d;
            bit_q <= bit_d;
            tx_q <= tx_d;
            rx_q <= rx_d;
            rsp_data_q <= rsp_data_d;
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            cs_q <= cs_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            busy_q <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign SCLK      = sclk_q;
    assign CS        = cs_q;
    assign MOSI      = mosi_q;
endmodule

// File: tb/tb_spi_master_scheduler.sv
// tb_spi_master_scheduler: vector table, directed corner cases and random rounds
// checked against a round-robin transaction model and an SPI slave model.
module tb_spi_master_scheduler;
    localparam int N = 4, DW = 8, CD = 2;
    localparam int LAT = CD * (1 + 2 * DW);
    localparam int G2G = CD * (2 + 2 * DW) + 1;

    typedef struct {int req; logic [DW-1:0] tx, slv, rsp;} vec_t;

    logic clk = 0, reset = 1;
    logic [N-1:0] req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0] req_ready, rsp_valid, CS;
    logic [DW-1:0] rsp_data;
    logic busy, SCLK, MOSI;
    logic MISO = 0;
    logic [N-1:0] v1 = '0;
    logic [N*DW-1:0] d1 = '0;
    logic [N-1:0] rr1, rs1, cs1;
    logic [DW-1:0] rd1;
    logic busy1, sclk1, mosi1;
    logic miso1 = 0;

    always #5 clk = ~clk;

    spi_master_scheduler #(.N_REQ(N), .DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO)
    );

    spi_master_scheduler #(.N_REQ(N), .DATA_W(DW), .CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_data(d1),
        .req_ready(rr1), .rsp_valid(rs1), .rsp_data(rd1), .busy(busy1),
        .SCLK(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(miso1)
    );

    int checks = 0, errors = 0, cyc = 0, rises = 0, multi_cs = 0, ptr_m = N - 1;
    int csl [N];
    logic [DW-1:0] cap, tx_b [N], slv [N], exp_b [N];
    logic sclk_p = 0;
    int g_idx[$], g_cyc[$], r_idx[$], r_cyc[$], r_rises[$], rise_cyc[$];
    logic [DW-1:0] r_dat[$], r_mosi[$];
    vec_t tbl [5];

    function automatic int oh2i(input logic [N-1:0] v);
        oh2i = -1;
        for (int i = 0; i < N; i++) if (v[i]) oh2i = i;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // bus monitor and slave model: slave puts its next LSB-first bit on MISO after each SCLK rise
    initial begin
        int c;
        for (int i = 0; i < N; i++) csl[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if ($countones(~CS) > 1) multi_cs++;
            for (int i = 0; i < N; i++) if (CS[i] === 1'b0) csl[i]++;
            if (|req_ready) begin g_idx.push_back(oh2i(req_ready)); g_cyc.push_back(cyc); end
            if (|rsp_valid) begin
                r_idx.push_back(oh2i(rsp_valid)); r_dat.push_back(rsp_data);
                r_mosi.push_back(cap); r_cyc.push_back(cyc); r_rises.push_back(rises);
            end
            if (SCLK && !sclk_p) begin
                c = oh2i(~CS);
                if (rises < DW) begin
                    cap[rises] = MOSI;
                    if (c >= 0) MISO = slv[c][rises];
                end
                rise_cyc.push_back(cyc);
                rises++;
            end
            if (&CS && !SCLK) rises = 0;
            sclk_p = SCLK;
        end
    end

    // model: grants go to the first pending requester after the last grant; late requests join after the first grant
    task automatic run_round(input string tag, input logic [N-1:0] mask, input logic [N-1:0] late, input logic [N-1:0] blip);
        int ord[$];
        int bg, br, p, since, n_i;
        int cs0 [N];
        logic [N-1:0] pend;
        bit added;
        bg = g_idx.size(); br = r_idx.size(); cs0 = csl;
        pend = mask; p = ptr_m; added = 0;
        while (pend != '0) begin
            for (int k = 1; k <= N; k++) if (pend[(p + k) % N]) begin p = (p + k) % N; break; end
            ord.push_back(p);
            pend[p] = 1'b0;
            if (!added) begin pend |= late; added = 1; end
        end
        ptr_m = p;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = tx_b[i];
        req_valid = mask; since = -1;
        for (int t = 0; t < 1000 && r_idx.size() - br < ord.size(); t++) begin
            @(negedge clk); #1;
            req_valid &= ~req_ready;
            if (since < 0 && g_idx.size() > bg) begin since = 0; req_valid |= late; end
            else if (since >= 0) since++;
            if (since == 5) req_valid |= blip;
            if (since == 6) req_valid &= ~blip;
        end
        req_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        chk({tag, " rsp count"}, r_idx.size() - br, ord.size());
        chk({tag, " grant count"}, g_idx.size() - bg, ord.size());
        chk({tag, " rsp_data held"}, rsp_data, exp_b[ord[$]]);
        foreach (ord[j]) if (bg + j < g_idx.size() && br + j < r_idx.size()) begin
            chk({tag, " grant idx"}, g_idx[bg+j], ord[j]);
            chk({tag, " rsp idx"}, r_idx[br+j], ord[j]);
            chk({tag, " rsp data"}, r_dat[br+j], exp_b[ord[j]]);
            chk({tag, " mosi byte"}, r_mosi[br+j], tx_b[ord[j]]);
            chk({tag, " sclk rises"}, r_rises[br+j], DW);
            chk({tag, " latency"}, r_cyc[br+j] - g_cyc[bg+j], LAT);
            if (j > 0) chk({tag, " grant spacing"}, g_cyc[bg+j] - g_cyc[bg+j-1], G2G);
        end
        for (int i = 0; i < N; i++) begin
            n_i = 0;
            foreach (ord[j]) if (ord[j] == i) n_i++;
            chk($sformatf("%s cs%0d low cycles", tag, i), csl[i] - cs0[i], n_i * LAT);
        end
    endtask

    initial begin
        int br, g1, r1, n1, c1, i1;
        int rc[$];
        logic p1;
        logic [DW-1:0] cap1, dat1;
        tbl[0] = '{0, 8'b01010011, 8'b00001001, 8'b00001001};
        tbl[1] = '{0, 8'h3C, 8'h98, 8'h98};
        tbl[2] = '{1, 8'h55, 8'hFF, 8'hFF};
        tbl[3] = '{2, 8'h5F, 8'h98, 8'h98};
        tbl[4] = '{3, 8'hA5, 8'h00, 8'h00};
        for (int i = 0; i < N; i++) begin tx_b[i] = '0; slv[i] = '0; exp_b[i] = '0; end
        repeat (3) @(negedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset SCLK", SCLK, 0);
        chk("reset CS", CS, 4'hF);
        chk("reset MOSI", MOSI, 0);
        chk("reset req_ready", req_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_data", rsp_data, 0);
        reset = 0;
        @(negedge clk); #1;
        foreach (tbl[k]) begin
            tx_b[tbl[k].req] = tbl[k].tx;
            slv[tbl[k].req] = tbl[k].slv;
            exp_b[tbl[k].req] = tbl[k].rsp;
            run_round($sformatf("vec%0d", k), N'(1) << tbl[k].req, '0, '0);
        end
        tx_b = '{8'h3C, 8'h55, 8'h5F, 8'hA5};
        slv = '{8'h98, 8'hFF, 8'h98, 8'h00};
        exp_b = slv;
        run_round("all4", 4'b1111, '0, '0);
        run_round("fair", 4'b0100, 4'b1010, '0);
        run_round("withdraw", 4'b0001, '0, 4'b0010);
        tx_b[0] = 8'hC3; slv[0] = 8'h5A; exp_b[0] = 8'h5A;
        req_data[DW-1:0] = 8'hC3; req_valid = 4'b0001; br = r_idx.size();
        for (int t = 0; t < 200 && rises < 4; t++) begin
            @(negedge clk); #1;
            req_valid &= ~req_ready;
        end
        chk("reset mid: reached 4th rise", rises, 4);
        reset = 1;
        #1;
        chk("reset mid SCLK", SCLK, 0);
        chk("reset mid CS", CS, 4'hF);
        chk("reset mid busy", busy, 0);
        chk("reset mid MOSI", MOSI, 0);
        req_valid = '0;
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (40) @(negedge clk);
        #1;
        chk("reset mid no rsp", r_idx.size() - br, 0);
        ptr_m = N - 1;
        run_round("after reset", 4'b0001, '0, '0);
        for (int r = 0; r < 20; r++) begin
            logic [N-1:0] m, l;
            m = N'($urandom_range(1, (1 << N) - 1));
            l = N'($urandom) & ~m;
            for (int i = 0; i < N; i++) begin
                tx_b[i] = DW'($urandom); slv[i] = DW'($urandom); exp_b[i] = slv[i];
            end
            run_round($sformatf("rand%0d", r), m, l, N'($urandom) & ~m & ~l);
        end
        g1 = -1; r1 = -1; n1 = 0; c1 = 0; i1 = -1; p1 = 0; cap1 = '0; dat1 = 'x;
        d1[DW-1:0] = 8'hFF; v1 = 4'b0001;
        for (int t = 0; t < 100 && r1 < 0; t++) begin
            @(negedge clk); #1;
            c1++;
            if (rr1[0]) begin g1 = c1; v1 = '0; end
            if (sclk1 && !p1) begin
                if (n1 < DW) cap1[n1] = mosi1;
                rc.push_back(c1);
                n1++;
            end
            p1 = sclk1;
            if (|rs1) begin r1 = c1; dat1 = rd1; i1 = oh2i(rs1); end
        end
        chk("div1 latency", r1 - g1, 1 * (1 + 2 * DW));
        chk("div1 rsp idx", i1, 0);
        chk("div1 rsp data", dat1, 8'h00);
        chk("div1 mosi byte", cap1, 8'hFF);
        chk("div1 sclk rises", n1, DW);
        if (rc.size() >= 2) chk("div1 sclk period", rc[1] - rc[0], 2);
        else chk("div1 sclk rise count", rc.size(), 2);
        chk("single CS low", multi_cs, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
